// File: rtl/pzcorebus_outstanding_id_limiter.sv
// pzcorebus_outstanding_id_limiter
//
// Request-side stage placed directly upstream of the ID assigner. It keeps one
// counter per local ID of non-posted commands still waiting for their response.
// A non-posted command whose ID already has MAX_OUTSTANDING commands in flight
// is stalled. Only the command handshake is gated; the other command fields
// bypass this block, so it adds no latency. A counter is decremented on the
// last beat of a response carrying that local (base-stripped) sid.
//
// A drain handshake stops new commands and reports when every ID is idle. It is
// used by reset and power sequencing.
//
// Ports
//   i_clk, i_rst           clock; synchronous active-high reset
//   i_slave_mcmd_valid     upstream command valid
//   o_slave_scmd_accept    upstream command accept (gated)
//   i_slave_non_posted     command expects a response
//   i_slave_mid            upstream command local ID
//   o_master_mcmd_valid    command valid toward the ID assigner (gated)
//   i_master_scmd_accept   command accept from the ID assigner
//   i_resp_valid/accept    response handshake tap (local side)
//   i_resp_sid, i_resp_last  response local ID and last-beat flag
//   i_drain_req            level drain request
//   o_drain_done           drain complete; all IDs idle and new commands held
//   o_idle                 every counter is zero
//   o_underflow            sticky; a response arrived for an ID whose count was zero
module pzcorebus_outstanding_id_limiter #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_slave_mcmd_valid,
  output logic                o_slave_scmd_accept,
  input  logic                i_slave_non_posted,
  input  logic [ID_WIDTH-1:0] i_slave_mid,
  output logic                o_master_mcmd_valid,
  input  logic                i_master_scmd_accept,
  input  logic                i_resp_valid,
  input  logic                i_resp_accept,
  input  logic [ID_WIDTH-1:0] i_resp_sid,
  input  logic                i_resp_last,
  input  logic                i_drain_req,
  output logic                o_drain_done,
  output logic                o_idle,
  output logic                o_underflow
);

  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [COUNT_WIDTH-1:0] cnt [NUM_IDS];
  logic [1:0]             state;
  logic [1:0]             state_next;
  logic                   block;
  logic                   cmd_fire;
  logic                   rsp_fire;
  logic                   idle;

  // Posted commands never consume a slot, so only the drain state can hold them.
  assign block = (state != ST_RUN) |
                 (i_slave_non_posted & (cnt[i_slave_mid] == CNT_MAX));

  assign o_master_mcmd_valid = i_slave_mcmd_valid & ~block;
  assign o_slave_scmd_accept = i_master_scmd_accept & ~block;

  assign cmd_fire = o_master_mcmd_valid & i_master_scmd_accept & i_slave_non_posted;
  assign rsp_fire = i_resp_valid & i_resp_accept & i_resp_last;

  always_comb begin
    // NOTE: a default assignment first in every always_comb. A path that leaves
    // a variable unassigned would infer a latch.
    idle = 1'b1;
    for (int i = 0; i < NUM_IDS; i++) begin
      if (cnt[i] != '0) idle = 1'b0;
    end
  end

  assign o_idle = idle;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the counter array is a bank of flops, not a RAM. Every entry is
      // reset so that o_idle is valid straight after reset.
      for (int i = 0; i < NUM_IDS; i++) cnt[i] <= '0;
      o_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IDS; i++) begin
        // A command and a response for the same ID in one cycle cancel out.
        // A decrement at zero is dropped; o_underflow records it instead.
        if (cmd_fire && (i_slave_mid == ID_WIDTH'(i)) &&
            !(rsp_fire && (i_resp_sid == ID_WIDTH'(i)))) begin
          // The block term keeps cnt at or below MAX, so this cannot wrap.
          cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
        end else if (rsp_fire && (i_resp_sid == ID_WIDTH'(i)) &&
                     !(cmd_fire && (i_slave_mid == ID_WIDTH'(i))) &&
                     (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - COUNT_WIDTH'(1);
        end
      end
      if (rsp_fire && (cnt[i_resp_sid] == '0)) o_underflow <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (i_drain_req) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (idle)              state_next = ST_DONE;
        else if (!i_drain_req) state_next = ST_RUN;
      end
      ST_DONE:  if (!i_drain_req) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then sample
    // the values from before the edge, whatever the order of the blocks.
    if (i_rst) state <= ST_RUN;
    else       state <= state_next;
  end

  // The command accepted in the cycle that drain is requested still completes,
  // because block only sees the registered state.
  assign o_drain_done = (state == ST_DONE);

endmodule

// File: tb/tb_pzcorebus_outstanding_id_limiter.sv
module tb_pzcorebus_outstanding_id_limiter;

  localparam int ID_WIDTH = 4;
  localparam int MAXO     = 4;
  localparam int NUM_IDS  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       mvalid_in, np, macc, rv, ra, rlast, drain;
  logic [3:0] mid, sid;
  logic       saccept_out, mvalid_out, drain_done, idle, underflow;

  always #5 clk = ~clk;

  pzcorebus_outstanding_id_limiter #(.ID_WIDTH(ID_WIDTH), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_slave_mcmd_valid(mvalid_in), .o_slave_scmd_accept(saccept_out),
    .i_slave_non_posted(np), .i_slave_mid(mid),
    .o_master_mcmd_valid(mvalid_out), .i_master_scmd_accept(macc),
    .i_resp_valid(rv), .i_resp_accept(ra), .i_resp_sid(sid), .i_resp_last(rlast),
    .i_drain_req(drain), .o_drain_done(drain_done), .o_idle(idle), .o_underflow(underflow)
  );

  typedef struct packed {
    logic valid, np; logic [3:0] mid; logic macc, rv, ra; logic [3:0] sid;
    logic last, drain, rst;
  } stim_t;

  typedef struct packed { logic mvalid, saccept, idle, done, uf; } exp_t;

  typedef enum int { M_RUN, M_DRAIN, M_DONE } mode_e;

  // Reference model: outstanding non-posted commands per ID, plus the drain mode.
  int    outstanding [NUM_IDS];
  mode_e mode;
  bit    uf_seen;
  stim_t prev;
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_zero();
    foreach (outstanding[i]) if (outstanding[i] != 0) return 0;
    return 1;
  endfunction

  function automatic bit blocked(input stim_t s);
    return (mode != M_RUN) || (s.np && outstanding[s.mid] >= MAXO);
  endfunction

  // Advance the model across one clock edge, using the inputs held before that edge.
  task automatic model_edge(input stim_t s);
    bit cf, rf, was_idle;
    if (s.rst) begin
      foreach (outstanding[i]) outstanding[i] = 0;
      mode = M_RUN; uf_seen = 0;
      return;
    end
    was_idle = all_zero();
    cf = s.valid && !blocked(s) && s.macc && s.np;
    rf = s.rv && s.ra && s.last;
    if (rf && outstanding[s.sid] == 0) uf_seen = 1;
    if (cf && rf && s.mid == s.sid) begin
      // one in, one out: no change
    end else begin
      if (cf) outstanding[s.mid] += 1;
      if (rf && outstanding[s.sid] > 0) outstanding[s.sid] -= 1;
    end
    case (mode)
      M_RUN:   if (s.drain) mode = M_DRAIN;
      M_DRAIN: if (was_idle) mode = M_DONE; else if (!s.drain) mode = M_RUN;
      default: if (!s.drain) mode = M_RUN;
    endcase
  endtask

  // One cycle: move the model across the edge, apply new inputs, and queue the
  // outputs the model expects for those inputs.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    model_edge(prev);
    {mvalid_in, np, mid, macc, rv, ra, sid, rlast, drain, rst} = s;
    e.mvalid  = s.valid && !blocked(s);
    e.saccept = s.macc && !blocked(s);
    e.idle    = all_zero();
    e.done    = (mode == M_DONE);
    e.uf      = uf_seen;
    sb.push_back(e);
    prev = s;
  endtask

  function automatic stim_t st(input int v, input int n, input int m, input int a,
                               input int r_v, input int r_a, input int s_id,
                               input int l, input int d, input int r);
    stim_t s;
    s.valid = v[0]; s.np = n[0]; s.mid = m[3:0]; s.macc = a[0];
    s.rv = r_v[0]; s.ra = r_a[0]; s.sid = s_id[3:0]; s.last = l[0];
    s.drain = d[0]; s.rst = r[0];
    return s;
  endfunction

  function automatic stim_t nop();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Monitor: every cycle the DUT presents outputs, compare them with the next
  // expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("mcmd_valid", 32'(mvalid_out), 32'(e.mvalid));
        check("scmd_accept", 32'(saccept_out), 32'(e.saccept));
        check("idle", 32'(idle), 32'(e.idle));
        check("drain_done", 32'(drain_done), 32'(e.done));
        check("underflow", 32'(underflow), 32'(e.uf));
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    prev = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    {mvalid_in, np, mid, macc, rv, ra, sid, rlast, drain, rst} = prev;
    foreach (outstanding[i]) outstanding[i] = 0;
    mode = M_RUN; uf_seen = 0;

    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(nop());
    @(negedge clk);
    check("reset_idle", 32'(idle), 32'd1);

    // Five non-posted ID3 commands: four fire and the fifth stalls.
    repeat (5) drive(st(1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("t1_fifth_valid", 32'(mvalid_out), 32'd0);
    check("t1_fifth_accept", 32'(saccept_out), 32'd0);
    drive(st(1, 1, 3, 1, 0, 0, 0, 0, 0, 0));
    drive(st(1, 1, 3, 1, 1, 1, 3, 1, 0, 0));   // last beat for ID3, cmd still held
    drive(st(1, 1, 3, 1, 0, 0, 0, 0, 0, 0));   // slot free: fires
    @(negedge clk);
    check("t1_refire", 32'(mvalid_out), 32'd1);

    // ID3 is full. A non-posted ID5 command and a posted ID3 command both pass.
    drive(st(1, 1, 5, 1, 0, 0, 0, 0, 0, 0));
    drive(st(1, 0, 3, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("t2_posted_pass", 32'(mvalid_out), 32'd1);

    // Command and response on the same or on different IDs in one cycle.
    repeat (2) drive(st(1, 1, 2, 1, 0, 0, 0, 0, 0, 0));
    drive(st(1, 1, 2, 1, 1, 1, 2, 1, 0, 0));
    drive(st(1, 1, 1, 1, 1, 1, 2, 1, 0, 0));

    // A response at zero count sets underflow. Non-last beats never decrement.
    drive(st(0, 0, 0, 0, 1, 1, 3, 0, 0, 0));
    drive(st(0, 0, 0, 0, 1, 1, 7, 1, 0, 0));
    repeat (2) drive(nop());
    @(negedge clk);
    check("t4_underflow", 32'(underflow), 32'd1);
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    drive(nop());

    // Drain with traffic. The entry-cycle command fires; later commands stall.
    repeat (2) drive(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    drive(st(1, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    repeat (2) drive(st(1, 1, 4, 1, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    check("t5_stalled", 32'(mvalid_out), 32'd0);
    drive(st(0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
    drive(st(0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
    drive(st(0, 0, 0, 0, 1, 1, 1, 1, 1, 0));
    repeat (3) drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    check("t5_done", 32'(drain_done), 32'd1);
    repeat (2) drive(st(1, 1, 4, 1, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a drain, with three outstanding on ID0.
    repeat (3) drive(st(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    drive(nop());
    @(negedge clk);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_done", 32'(drain_done), 32'd0);

    // Random traffic concentrated on a few IDs so the full-count limit is hit often.
    for (int c = 0; c < 3000; c++) begin
      s.valid = ($urandom_range(0, 3) != 0);
      s.np    = ($urandom_range(0, 4) != 0);
      s.mid   = 4'($urandom_range(0, 3));
      s.macc  = ($urandom_range(0, 3) != 0);
      s.sid   = 4'($urandom_range(0, 3));
      s.rv    = ($urandom_range(0, 2) == 0) && (outstanding[s.sid] > 0);
      s.ra    = ($urandom_range(0, 3) != 0);
      s.last  = ($urandom_range(0, 2) != 0);
      s.drain = (c % 400) > 330;
      s.rst   = ($urandom_range(0, 999) == 0);
      drive(s);
    end
    drive(st(0, 0, 0, 0, 1, 1, 9, 1, 0, 0));   // stray response on an idle ID
    drive(nop());

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
